// File: rtl/demux_stream.sv
// Four-way stream demultiplexer: one upstream word is routed into a one-entry
// output register per channel, with a per-channel delivered-word counter.
module demux_stream #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    // Handshake: a word moves on any edge where its valid and ready are both
    // high. Valid never waits on ready; in_ready never looks at in_valid.

    logic [WIDTH-1:0] data_q [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [3:0]       valid_q;

    logic       in_xfer;
    logic [3:0] sel_onehot;
    logic [3:0] load;
    logic [3:0] drain;

    // A slot can take a new word if it is empty or is being emptied this cycle.
    assign in_ready   = ~valid_q[select] | out_ready[select];
    assign in_xfer    = in_valid & in_ready;
    assign sel_onehot = 4'b0001 << select;
    assign load       = {4{in_xfer}} & sel_onehot;
    assign drain      = valid_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // Load wins over drain so a simultaneous refill keeps valid high.
                if (load[k]) begin
                    data_q[k]  <= in_data;
                    valid_q[k] <= 1'b1;
                end else if (drain[k]) begin
                    valid_q[k] <= 1'b0;
                end
                if (drain[k]) begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];
    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed vector table, corner-case
// sequences, and a randomized run against a queue-based channel model.
module tb_demux_stream;

    localparam int WIDTH = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;

    logic [WIDTH-1:0] outs [4];
    logic [CNT_W-1:0] cnts [4];
    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign cnts[0] = cnt0;
    assign cnts[1] = cnt1;
    assign cnts[2] = cnt2;
    assign cnts[3] = cnt3;

    demux_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .select(select),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [1:0] d, input logic [1:0] s, input logic v, input logic [3:0] r);
        in_data   = d;
        select    = s;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'd0, 2'd0, 1'b0, 4'b0000);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] d;
        logic [1:0] s;
        logic       v;
        logic [3:0] r;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [1:0] exp_out;
    } vec_t;

    vec_t vecs [6];

    // scoreboard / reference model: each channel is a queue of at most one word
    logic [WIDTH-1:0] exp_q [4][$];
    logic [WIDTH-1:0] last_word [4];
    int               cnt_m [4];

    initial begin
        logic [1:0] d, s;
        logic       v, hold, exp_rdy, accept;
        logic [3:0] r;

        rst_n = 1'b0;
        drive(2'd0, 2'd0, 1'b0, 4'b0000);
        #2;
        check("reset_out_valid", out_valid, 4'b0000);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
        check("reset_outs", {out0, out1, out2, out3}, 8'h00);
        do_reset();

        // directed vector table, applied from reset
        vecs[0] = '{2'd2, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2};
        vecs[1] = '{2'd1, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0110, 2'd1};
        vecs[2] = '{2'd3, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0110, 2'd1};
        vecs[3] = '{2'd3, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0110, 2'd3};
        vecs[4] = '{2'd0, 2'd0, 1'b1, 4'b0100, 1'b1, 4'b0011, 2'd0};
        vecs[5] = '{2'd2, 2'd2, 1'b0, 4'b0011, 1'b1, 4'b0000, 2'd2};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].d, vecs[i].s, vecs[i].v, vecs[i].r);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
            tick();
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
            check($sformatf("vec%0d_out", i), outs[vecs[i].s], vecs[i].exp_out);
            if (i == 0) check("route_others_zero", {out0, out1, out3}, 6'b0);
        end

        // stall on a full channel, then release
        do_reset();
        drive(2'd1, 2'd1, 1'b1, 4'b0000);
        tick();
        drive(2'd3, 2'd1, 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            tick();
            check("stall_out1", out1, 2'd1);
            check("stall_valid1", out_valid[1], 1'b1);
        end
        drive(2'd3, 2'd1, 1'b1, 4'b0010);
        #1;
        check("release_in_ready", in_ready, 1'b1);
        tick();
        check("release_out1", out1, 2'd3);
        check("release_valid1", out_valid[1], 1'b1);

        // back-to-back streaming on channel 3
        do_reset();
        for (int w = 0; w < 4; w++) begin
            drive(2'(w), 2'd3, 1'b1, 4'b1000);
            #1;
            check("stream_in_ready", in_ready, 1'b1);
            tick();
            check("stream_out3", out3, w);
            check("stream_valid3", out_valid[3], 1'b1);
        end
        drive(2'd0, 2'd3, 1'b0, 4'b1000);
        tick();
        check("stream_cnt3", cnt3, 8'd4);
        check("stream_drained", out_valid[3], 1'b0);

        // counter wrap on channel 0: 255 transfers, then the 256th
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(2'(i), 2'd0, 1'b1, 4'b0001);
            tick();
        end
        check("wrap_cnt0_255", cnt0, 8'd255);
        drive(2'd0, 2'd0, 1'b0, 4'b0001);
        tick();
        check("wrap_cnt0_0", cnt0, 8'd0);
        check("wrap_others", {cnt1, cnt2, cnt3}, 24'h0);

        // asynchronous reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(2'd1, 2'd2, 1'b1, 4'b0100);
            tick();
        end
        drive(2'd0, 2'd2, 1'b0, 4'b0100);
        tick();
        drive(2'd3, 2'd0, 1'b1, 4'b0000);
        tick();
        drive(2'd3, 2'd1, 1'b1, 4'b0000);
        tick();
        drive(2'd3, 2'd3, 1'b1, 4'b0000);
        tick();
        drive(2'd0, 2'd0, 1'b0, 4'b0000);
        check("pre_reset_ov", out_valid, 4'b1011);
        check("pre_reset_cnt2", cnt2, 8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ov", out_valid, 4'b0000);
        check("midrst_outs", {out0, out1, out2, out3}, 8'h00);
        check("midrst_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run against the queue model
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            last_word[k] = '0;
            cnt_m[k] = 0;
        end
        hold = 1'b0;
        d = '0;
        s = '0;
        v = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!hold) begin
                d = 2'($urandom_range(0, 3));
                s = 2'($urandom_range(0, 3));
                v = ($urandom_range(0, 9) < 7);
            end
            r = 4'($urandom_range(0, 15));
            drive(d, s, v, r);
            #1;
            exp_rdy = (exp_q[s].size() == 0) || r[s];
            check("rand_in_ready", in_ready, exp_rdy);
            accept = v && exp_rdy;
            hold   = v && !exp_rdy;
            for (int k = 0; k < 4; k++) begin
                if (r[k] && exp_q[k].size() > 0)
                    check($sformatf("rand_deliver%0d", k), outs[k], exp_q[k][0]);
            end
            tick();
            for (int k = 0; k < 4; k++) begin
                if (r[k] && exp_q[k].size() > 0) begin
                    void'(exp_q[k].pop_front());
                    cnt_m[k] = (cnt_m[k] + 1) % (1 << CNT_W);
                end
            end
            if (accept) begin
                exp_q[s].push_back(d);
                last_word[s] = d;
            end
            for (int k = 0; k < 4; k++) begin
                check($sformatf("rand_valid%0d", k), out_valid[k], exp_q[k].size() > 0);
                check($sformatf("rand_out%0d", k), outs[k], last_word[k]);
                check($sformatf("rand_cnt%0d", k), cnts[k], cnt_m[k]);
            end
        end

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
